// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter slice.
package rr_arb_pkg;

   localparam int REQ_NUM_DEF = 8;

   // Width of a binary index into n requesters; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
interface rr_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int REQ_NUM   = REQ_NUM_DEF,
   parameter int IDX_WIDTH = idx_width(REQ_NUM)
);

   logic [REQ_NUM-1:0]   req;
   logic                 gnt_rdy;
   logic                 gnt_vld;
   logic [REQ_NUM-1:0]   gnt;
   logic [IDX_WIDTH-1:0] gnt_idx;

   modport slave  (input  req, gnt_rdy, output gnt_vld, gnt, gnt_idx);
   modport master (output req, gnt_rdy, input  gnt_vld, gnt, gnt_idx);

endinterface

// File: rtl/arb_fixed_prio.sv
// Combinational fixed-priority picker: lowest set bit wins.
module arb_fixed_prio #(
   parameter int N = 8
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o,
   output logic         any_o
);

   // Two's-complement trick isolates the lowest set bit.
   always_comb begin
      gnt_o = req_i & (~req_i + N'(1));
      any_o = |req_i;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with valid/ready grant handshake.
module rr_arbiter
   import rr_arb_pkg::*;
#(
   parameter int REQ_NUM   = REQ_NUM_DEF,
   parameter int IDX_WIDTH = idx_width(REQ_NUM)
) (
   input  logic         clk,
   input  logic         rst,
   rr_arbiter_if.slave  bus
);

   logic                 gnt_vld_q, gnt_vld_d;
   logic [REQ_NUM-1:0]   gnt_q, gnt_d;
   logic [IDX_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

   logic                 accept, hold;
   logic [IDX_WIDTH-1:0] ptr_inc, ptr_sel;
   logic [REQ_NUM-1:0]   cand, mask, oh_msk, oh_all, sel_oh;
   logic                 any_msk, any_all;
   logic [IDX_WIDTH-1:0] sel_idx;

   // Handshake decode and candidate/pointer selection. On an accept the
   // search already starts past the winner, so back-to-back grants rotate.
   always_comb begin
      accept  = gnt_vld_q & bus.gnt_rdy;
      hold    = gnt_vld_q & ~bus.gnt_rdy;
      ptr_inc = (gnt_idx_q == IDX_WIDTH'(REQ_NUM - 1)) ? '0 : gnt_idx_q + IDX_WIDTH'(1);
      ptr_sel = accept ? ptr_inc : ptr_q;
      cand    = accept ? (bus.req & ~gnt_q) : bus.req;
      for (int i = 0; i < REQ_NUM; i++) mask[i] = (i >= int'(ptr_sel));
   end

   arb_fixed_prio #(.N(REQ_NUM)) u_fp_msk (.req_i(cand & mask), .gnt_o(oh_msk), .any_o(any_msk));
   arb_fixed_prio #(.N(REQ_NUM)) u_fp_all (.req_i(cand),        .gnt_o(oh_all), .any_o(any_all));

   // Prefer the winner at/above the pointer, else wrap to the lowest; encode
   // the index from the one-hot here so both register together.
   always_comb begin
      sel_oh  = any_msk ? oh_msk : oh_all;
      sel_idx = '0;
      for (int i = 0; i < REQ_NUM; i++)
         if (sel_oh[i]) sel_idx = sel_idx | IDX_WIDTH'(i);
   end

   // Next state: freeze everything while a grant is stalled.
   always_comb begin
      gnt_vld_d = gnt_vld_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      if (!hold) begin
         gnt_vld_d = any_all;
         gnt_d     = sel_oh;
         gnt_idx_d = sel_idx;
         if (accept) ptr_d = ptr_inc;
      end
   end

   // Output and pointer registers; reset wins over any accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_vld_q <= 1'b0;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         ptr_q     <= '0;
      end else begin
         gnt_vld_q <= gnt_vld_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.gnt_vld = gnt_vld_q;
   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = gnt_idx_q;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 8: number of requesters, legal range 1..64.
REQ-002 Parameter IDX_WIDTH, default (REQ_NUM==1)?1:$clog2(REQ_NUM): width of the binary grant index.
REQ-003 Port clk  input  1: single clock, all state on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port req  input  REQ_NUM: request vector, bit i = requester i.
REQ-006 Port gnt_rdy  input  1: downstream ready to accept the current grant.
REQ-007 Port gnt_vld  output  1: a grant is presented.
REQ-008 Port gnt  output  REQ_NUM: one-hot grant vector, all-zero when gnt_vld=0.
REQ-009 Port gnt_idx  output  IDX_WIDTH: binary index of the set bit of gnt, 0 when gnt_vld=0.

Function
REQ-010 The block SHALL be a registered round-robin arbiter; gnt_vld, gnt, gnt_idx and the priority pointer ptr (IDX_WIDTH bits) are flops.
REQ-011 Accept event: gnt_vld=1 and gnt_rdy=1 in the same cycle.
REQ-012 Latency: a request arriving at an idle arbiter (gnt_vld=0) SHALL produce gnt_vld=1 on the next rising edge.
REQ-013 Selection: from the candidate vector C, pick the lowest set bit at index >= ptr; if none, pick the lowest set bit overall; if C=0, no grant.
REQ-014 When gnt_vld=0, C=req.
REQ-015 On an accept, C=req & ~gnt (the accepted requester is excluded for that evaluation); ptr SHALL load (gnt_idx+1) mod REQ_NUM; the new grant from C SHALL register on the same edge, giving back-to-back grants with no bubble.
REQ-016 While gnt_vld=1 and gnt_rdy=0, gnt, gnt_idx and ptr SHALL hold, regardless of req changes, including deassertion of the granted bit.
REQ-017 On an accept with C=0, gnt_vld, gnt and gnt_idx SHALL clear on the next edge.
REQ-018 gnt SHALL have exactly one bit set whenever gnt_vld=1, and gnt_idx SHALL equal that bit's position.
REQ-019 Wrap-around: with ptr=REQ_NUM-1 and only req[0] set, req[0] SHALL be granted; ptr after accepting index REQ_NUM-1 SHALL be 0.
REQ-020 Fairness: with all requests continuously asserted and gnt_rdy=1, grants SHALL cycle 0,1,...,REQ_NUM-1,0,... one per cycle.
REQ-021 REQ_NUM=1: gnt=req registered under the same handshake; ptr stays 0; gnt_idx stays 0.
REQ-022 gnt_rdy while gnt_vld=0 SHALL have no effect.

Reset
REQ-023 On rst=1 at a rising edge, gnt_vld=0, gnt=0, gnt_idx=0 and ptr=0, overriding any accept or request in that cycle.
REQ-024 Reset mid-grant SHALL drop the pending grant without ptr advance; the first grant after reset release follows REQ-012 with ptr=0.

Structure
REQ-025 A shared package rr_arb_pkg SHALL hold the IDX_WIDTH derivation function and the default REQ_NUM constant.
REQ-026 A sub-module arb_fixed_prio (combinational lowest-set-bit picker with one-hot output and any-valid flag) SHALL be instantiated twice: once on the ptr-masked candidates, once on the unmasked candidates.
REQ-027 gnt_idx SHALL be derived from the selected one-hot vector before the output register, not from a separate encoder after it.

Verification
REQ-028 Reset: assert rst with req=8'hFF for 2 cycles -> gnt_vld=0, gnt=0, gnt_idx=0 throughout; first cycle after release -> gnt=8'h01, gnt_idx=0.
REQ-029 Full load: req=8'hFF, gnt_rdy=1 constant -> gnt_idx sequence 0,1,2,...,7,0 on consecutive cycles, gnt_vld never drops.
REQ-030 Backpressure: req=8'h0A, gnt_rdy=0 for 5 cycles -> gnt=8'h02 stable; drop req[1] during the stall -> gnt still 8'h02; gnt_rdy=1 -> next cycle gnt=8'h08, gnt_idx=3.
REQ-031 Wrap: grant and accept index 7 with req=8'h81 -> next gnt=8'h01, ptr=0; then with req=8'h81 still asserted -> gnt=8'h80 following accept of index 0.
REQ-032 Drain: req=8'h04 single pulse, gnt_rdy=1 -> gnt_vld high exactly one cycle with gnt_idx=2, then gnt_vld=0, gnt=0, gnt_idx=0.
REQ-033 Mid-operation reset: stalled grant gnt_idx=5, assert rst one cycle with gnt_rdy=1 -> no accept counted, after release with req=8'h30 -> gnt_idx=4 (ptr=0).
